multicycle_control_fsm: RTL and testbench

Multi-cycle successor to the single-cycle decoder. It sequences each RV32I instruction through FETCH, DECODE, EXEC, MEM and WB over a shared, variable-latency memory port. It issues per-state datapath strobes, halts on SYSTEM and faults on illegal opcodes or memory timeout. It sits between the instruction register and the multicycle datapath (PC, IR, register file, ALU, memory mux).

---
 rtl/multicycle_control_fsm.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared
// variable-latency memory port, with HALT on SYSTEM and sticky FAULT.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode[4:0]         instr[6:2] from IR (valid from DECODE onward)
//   branch_taken        comparator result, used in EXEC
//   mem_ready           memory completion, used while mem_req=1
//   resume              pulse that leaves HALT
//   mem_req/mem_we/iord memory request, write, address select (0=PC,1=ALU)
//   ir_write/pc_write   IR load, PC update; pc_src[1:0] selects next PC
//   branch              branch instruction in EXEC
//   alu_src1/alu_src2   ALU operand selects; alu_op[1:0] ALU function
//   mem_to_reg[1:0]     writeback select; reg_write register-file strobe
//   halted/fault        in HALT / in FAULT; fault_code[1:0] 01=illegal 10=timeout
//   state[2:0]          encoded state for debug
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8,
    parameter bit SYSTEM_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    input  logic       resume,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       branch,
    output logic       alu_src1,
    output logic       alu_src2,
    output logic [1:0] alu_op,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       halted,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    localparam logic [4:0] OP_FENCE  = 5'b00011;

    localparam int             TO_M1    = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit             TO_EN    = (MEM_TIMEOUT > 0);

    state_t           st_q, st_n;
    logic [4:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       fc_q, fc_n;
    logic             tmo;

    // Last permitted wait cycle with the memory still not ready; a
    // mem_ready in this same cycle completes the access instead.
    assign tmo = TO_EN && (cnt_q == TO_LAST) && !mem_ready;

    always_comb begin
        st_n       = st_q;
        fc_n       = fc_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        branch     = 1'b0;
        alu_src1   = 1'b0;
        alu_src2   = 1'b0;
        alu_op     = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        fault_code = fc_q;
        state      = st_q;

        // ALU controls stay stable from EXEC through MEM and WB.
        if (st_q == S_EXEC || st_q == S_MEM || st_q == S_WB) begin
            case (op_q)
                OP_R:      begin alu_op = 2'b10; end
                OP_I:      begin alu_src2 = 1'b1; alu_op = 2'b10; end
                OP_LOAD,
                OP_STORE,
                OP_JALR:   begin alu_src2 = 1'b1; end
                OP_BRANCH: begin alu_op = 2'b01; end
                OP_JAL,
                OP_AUIPC:  begin alu_src1 = 1'b1; alu_src2 = 1'b1; end
                OP_LUI:    begin alu_src2 = 1'b1; alu_op = 2'b11; end
                default:   begin alu_op = 2'b00; end
            endcase
        end

        unique case (st_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    st_n     = S_DECODE;
                end else if (tmo) begin
                    st_n = S_FAULT;
                    fc_n = 2'b10;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_SYSTEM: begin
                        if (SYSTEM_HALT) begin
                            st_n = S_HALT;
                        end else begin
                            pc_write = 1'b1;
                            st_n     = S_FETCH;
                        end
                    end
                    OP_FENCE: begin
                        pc_write = 1'b1;
                        st_n     = S_FETCH;
                    end
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                    OP_JALR, OP_JAL, OP_AUIPC, OP_LUI: begin
                        st_n = S_EXEC;
                    end
                    default: begin
                        st_n = S_FAULT;
                        fc_n = 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH) begin
                    branch   = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = branch_taken ? 2'b01 : 2'b00;
                    st_n     = S_FETCH;
                end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    st_n = S_MEM;
                end else begin
                    st_n = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (mem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_write = 1'b1;
                        st_n     = S_FETCH;
                    end else begin
                        st_n = S_WB;
                    end
                end else if (tmo) begin
                    st_n = S_FAULT;
                    fc_n = 2'b10;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                st_n      = S_FETCH;
                case (op_q)
                    OP_LOAD: mem_to_reg = 2'b00;
                    OP_JAL:  begin mem_to_reg = 2'b10; pc_src = 2'b01; end
                    OP_JALR: begin mem_to_reg = 2'b10; pc_src = 2'b10; end
                    default: mem_to_reg = 2'b01;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    pc_write = 1'b1;
                    st_n     = S_FETCH;
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                st_n = S_FETCH;
            end
        endcase

        // Reset aborts any in-flight instruction: nothing leaves the block.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            branch     = 1'b0;
            alu_src1   = 1'b0;
            alu_src2   = 1'b0;
            alu_op     = 2'b00;
            mem_to_reg = 2'b00;
            reg_write  = 1'b0;
            halted     = 1'b0;
            fault      = 1'b0;
            fault_code = 2'b00;
            state      = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= S_FETCH;
            op_q  <= 5'd0;
            cnt_q <= '0;
            fc_q  <= 2'b00;
        end else begin
            st_q <= st_n;
            fc_q <= fc_n;
            if (st_q == S_DECODE) begin
                op_q <= opcode;
            end
            // Any state change restarts the wait count, so FETCH and MEM
            // always begin each access from zero.
            if (st_n != st_q) begin
                cnt_q <= '0;
            end else if (mem_req && !mem_ready && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm (MEM_TIMEOUT=4).
// Stimulus pushes per-cycle expected outputs; a monitor pops and compares.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] opcode = 5'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       resume = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       branch, alu_src1, alu_src2;
    logic [1:0] alu_op, mem_to_reg;
    logic       reg_write, halted, fault;
    logic [1:0] fault_code;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t q[$];

    multicycle_control_fsm #(
        .MEM_TIMEOUT(4),
        .CNT_W(8),
        .SYSTEM_HALT(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .resume(resume), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .branch(branch), .alu_src1(alu_src1),
        .alu_src2(alu_src2), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .halted(halted), .fault(fault), .fault_code(fault_code),
        .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] R  = 5'b01100, LD = 5'b00000, ST = 5'b01000;
    localparam logic [4:0] BR = 5'b11000, JR = 5'b11001, JL = 5'b11011;
    localparam logic [4:0] AU = 5'b00101, LU = 5'b01101, SY = 5'b11100;
    localparam logic [4:0] FE = 5'b00011, IL = 5'b11111;

    // Output field order: req we iord irw pcw _ pcs _ br a1 a2 _ aop _
    // m2r _ rw halted fault _ fault_code
    localparam logic [18:0] Z     = 19'b00000_00_000_00_00_000_00;
    localparam logic [18:0] F_RDY = 19'b10010_00_000_00_00_000_00;
    localparam logic [18:0] F_WT  = 19'b10000_00_000_00_00_000_00;
    localparam logic [18:0] D_PCW = 19'b00001_00_000_00_00_000_00;

    task automatic cyc(input string nm, input logic r, input logic [4:0] op,
                       input logic rdy, input logic bt, input logic res,
                       input logic [2:0] st, input logic [18:0] o);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        opcode       = op;
        mem_ready    = rdy;
        branch_taken = bt;
        resume       = res;
        e.name = nm;
        e.v    = {st, o};
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [21:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {state, mem_req, mem_we, iord, ir_write, pc_write,
                       pc_src, branch, alu_src1, alu_src2, alu_op,
                       mem_to_reg, reg_write, halted, fault, fault_code};
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL %s got=%b want=%b", e.name, act, e.v);
                end
            end
        end
    end

    initial begin : stim
        cyc("rst0", 1, 0, 0, 0, 0, 3'd0, Z);
        cyc("rst1", 1, 0, 1, 0, 0, 3'd0, Z);
        // R-type, zero wait; resume outside HALT is ignored
        cyc("r_fetch", 0, R, 1, 0, 0, 3'd0, F_RDY);
        cyc("r_dec",   0, R, 1, 0, 1, 3'd1, Z);
        cyc("r_exec",  0, R, 1, 0, 1, 3'd2, 19'b00000_00_000_10_00_000_00);
        cyc("r_wb",    0, R, 1, 0, 0, 3'd4, 19'b00001_00_000_10_01_100_00);
        // LOAD with 3 data-memory wait cycles, ready in the timeout cycle
        cyc("ld_fetch", 0, LD, 1, 0, 0, 3'd0, F_RDY);
        cyc("ld_dec",   0, LD, 1, 0, 0, 3'd1, Z);
        cyc("ld_exec",  0, LD, 0, 0, 0, 3'd2, 19'b00000_00_001_00_00_000_00);
        cyc("ld_mem0",  0, LD, 0, 0, 0, 3'd3, 19'b10100_00_001_00_00_000_00);
        cyc("ld_mem1",  0, LD, 0, 0, 0, 3'd3, 19'b10100_00_001_00_00_000_00);
        cyc("ld_mem2",  0, LD, 0, 0, 0, 3'd3, 19'b10100_00_001_00_00_000_00);
        cyc("ld_mem3",  0, LD, 1, 0, 0, 3'd3, 19'b10100_00_001_00_00_000_00);
        cyc("ld_wb",    0, LD, 1, 0, 0, 3'd4, 19'b00001_00_001_00_00_100_00);
        // STORE
        cyc("st_fetch", 0, ST, 1, 0, 0, 3'd0, F_RDY);
        cyc("st_dec",   0, ST, 1, 0, 0, 3'd1, Z);
        cyc("st_exec",  0, ST, 1, 0, 0, 3'd2, 19'b00000_00_001_00_00_000_00);
        cyc("st_mem",   0, ST, 1, 0, 0, 3'd3, 19'b11101_00_001_00_00_000_00);
        // BRANCH taken, then not taken
        cyc("bt_fetch", 0, BR, 1, 0, 0, 3'd0, F_RDY);
        cyc("bt_dec",   0, BR, 1, 0, 0, 3'd1, Z);
        cyc("bt_exec",  0, BR, 1, 1, 0, 3'd2, 19'b00001_01_100_01_00_000_00);
        cyc("bn_fetch", 0, BR, 1, 1, 0, 3'd0, F_RDY);
        cyc("bn_dec",   0, BR, 1, 1, 0, 3'd1, Z);
        cyc("bn_exec",  0, BR, 1, 0, 0, 3'd2, 19'b00001_00_100_01_00_000_00);
        // JAL, JALR, LUI, AUIPC
        cyc("jal_fetch", 0, JL, 1, 0, 0, 3'd0, F_RDY);
        cyc("jal_dec",   0, JL, 1, 0, 0, 3'd1, Z);
        cyc("jal_exec",  0, JL, 1, 0, 0, 3'd2, 19'b00000_00_011_00_00_000_00);
        cyc("jal_wb",    0, JL, 1, 0, 0, 3'd4, 19'b00001_01_011_00_10_100_00);
        cyc("jr_fetch",  0, JR, 1, 0, 0, 3'd0, F_RDY);
        cyc("jr_dec",    0, JR, 1, 0, 0, 3'd1, Z);
        cyc("jr_exec",   0, JR, 1, 0, 0, 3'd2, 19'b00000_00_001_00_00_000_00);
        cyc("jr_wb",     0, JR, 1, 0, 0, 3'd4, 19'b00001_10_001_00_10_100_00);
        cyc("lui_fetch", 0, LU, 1, 0, 0, 3'd0, F_RDY);
        cyc("lui_dec",   0, LU, 1, 0, 0, 3'd1, Z);
        cyc("lui_exec",  0, LU, 1, 0, 0, 3'd2, 19'b00000_00_001_11_00_000_00);
        cyc("lui_wb",    0, LU, 1, 0, 0, 3'd4, 19'b00001_00_001_11_01_100_00);
        cyc("au_fetch",  0, AU, 1, 0, 0, 3'd0, F_RDY);
        cyc("au_dec",    0, AU, 1, 0, 0, 3'd1, Z);
        cyc("au_exec",   0, AU, 1, 0, 0, 3'd2, 19'b00000_00_011_00_00_000_00);
        cyc("au_wb",     0, AU, 1, 0, 0, 3'd4, 19'b00001_00_011_00_01_100_00);
        // FENCE
        cyc("fe_fetch", 0, FE, 1, 0, 0, 3'd0, F_RDY);
        cyc("fe_dec",   0, FE, 1, 0, 0, 3'd1, D_PCW);
        // SYSTEM -> HALT, resume
        cyc("sy_fetch", 0, SY, 1, 0, 0, 3'd0, F_RDY);
        cyc("sy_dec",   0, SY, 1, 0, 0, 3'd1, Z);
        cyc("halt0",    0, SY, 1, 0, 0, 3'd5, 19'b00000_00_000_00_00_010_00);
        cyc("halt_res", 0, SY, 1, 0, 1, 3'd5, 19'b00001_00_000_00_00_010_00);
        cyc("post_res", 0, R,  0, 0, 0, 3'd0, F_WT);
        // JAL aborted by reset in WB
        cyc("jx_fetch", 0, JL, 1, 0, 0, 3'd0, F_RDY);
        cyc("jx_dec",   0, JL, 1, 0, 0, 3'd1, Z);
        cyc("jx_exec",  0, JL, 1, 0, 0, 3'd2, 19'b00000_00_011_00_00_000_00);
        cyc("jx_rstwb", 1, JL, 1, 0, 0, 3'd0, Z);
        // illegal opcode
        cyc("il_fetch", 0, IL, 1, 0, 0, 3'd0, F_RDY);
        cyc("il_dec",   0, IL, 1, 0, 0, 3'd1, Z);
        cyc("il_flt0",  0, IL, 1, 0, 1, 3'd6, 19'b00000_00_000_00_00_001_01);
        cyc("il_flt1",  0, R,  1, 0, 0, 3'd6, 19'b00000_00_000_00_00_001_01);
        cyc("il_rst",   1, R,  0, 0, 0, 3'd0, Z);
        // fetch timeout with mem_ready stuck low
        cyc("to_f0",  0, R, 0, 0, 0, 3'd0, F_WT);
        cyc("to_f1",  0, R, 0, 0, 0, 3'd0, F_WT);
        cyc("to_f2",  0, R, 0, 0, 0, 3'd0, F_WT);
        cyc("to_f3",  0, R, 0, 0, 0, 3'd0, F_WT);
        cyc("to_flt0", 0, R, 1, 0, 1, 3'd6, 19'b00000_00_000_00_00_001_10);
        cyc("to_flt1", 0, R, 1, 0, 0, 3'd6, 19'b00000_00_000_00_00_001_10);
        cyc("to_rst",  1, R, 0, 0, 0, 3'd0, Z);
        // mem_ready arriving in the timeout cycle completes the fetch
        cyc("nt_f0",  0, FE, 0, 0, 0, 3'd0, F_WT);
        cyc("nt_f1",  0, FE, 0, 0, 0, 3'd0, F_WT);
        cyc("nt_f2",  0, FE, 0, 0, 0, 3'd0, F_WT);
        cyc("nt_f3",  0, FE, 1, 0, 0, 3'd0, F_RDY);
        cyc("nt_dec", 0, FE, 1, 0, 0, 3'd1, D_PCW);
        cyc("nt_ret", 0, FE, 0, 0, 0, 3'd0, F_WT);

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
